matmul_seq_ctrl: RTL

- Sequential 4x4 matrix-multiply engine and controller built around one shared multiply-accumulate unit.
- Loads operand matrices A and B over a valid/ready input stream, then computes C = A x B element by element. It issues one MAC per cycle and streams the 16 results out over a valid/ready output port.
- Serves as the area-efficient companion to the combinational 4x4 multiplier, for contexts where 64 parallel multipliers are too costly.

---
 rtl/matmul_pkg.sv | 20 ++
 rtl/matmul_seq_ctrl_if.sv | 26 ++
 rtl/matmul_mac.sv | 32 +++
 rtl/matmul_seq_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and default widths for the sequential 4x4 matrix-multiply engine.
package matmul_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned N      = 4;
  localparam int unsigned OUT_W  = 16;

  // Accumulator wide enough for N full-width products without overflow.
  function automatic int unsigned acc_width(input int unsigned data_w, input int unsigned n);
    return 2 * data_w + $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    MAC,
    OUT
  } state_e;

endpackage

// File: rtl/matmul_seq_ctrl_if.sv
// Operand load stream, result stream and status bundle of the matmul engine.
interface matmul_seq_ctrl_if;
  import matmul_pkg::*;

  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [OUT_W-1:0]  out_data;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic              ovf;

  modport master (
    output start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, done, ovf
  );

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, done, ovf
  );

endinterface

// File: rtl/matmul_mac.sv
// Unsigned multiply-accumulate with a registered running sum.
// acc presents the sum including the current product, so callers can capture the final term directly.
module matmul_mac #(
  parameter int unsigned OP_W  = 8,
  parameter int unsigned SUM_W = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  input  logic             clr,
  input  logic             en,
  output logic [SUM_W-1:0] acc
);

  localparam int unsigned PROD_W = 2 * OP_W;

  logic [PROD_W-1:0] prod;
  logic [SUM_W-1:0]  acc_q;

  assign prod = PROD_W'(a) * PROD_W'(b);
  assign acc  = (clr ? '0 : acc_q) + SUM_W'(prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc;
    end
  end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequential 4x4 matrix multiplier: loads A then B, issues one MAC per cycle, streams C row-major.
// Define MATMUL_SAT_EN to saturate results at 2^OUT_W-1 and report a sticky ovf; otherwise results wrap.
module matmul_seq_ctrl
  import matmul_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  matmul_seq_ctrl_if.slave bus
);

  localparam int unsigned ACC_W     = acc_width(DATA_W, N);
  localparam int unsigned IDX_W     = $clog2(N);
  localparam int unsigned RF_D      = 2 * N * N;
  localparam int unsigned ADDR_W    = $clog2(RF_D);
  localparam int unsigned LAST_BEAT = RF_D - 1;

  state_e state, state_n;

  logic [IDX_W-1:0]  i_q, j_q, k_q, i_n, j_n, k_n;
  logic [ADDR_W-1:0] ld_q, ld_n;
  logic              in_ready_q, in_ready_n;
  logic              out_valid_q, out_valid_n;
  logic [OUT_W-1:0]  out_data_q, out_data_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic              ovf_q, ovf_n;

  logic [DATA_W-1:0] rf [RF_D];

  logic              hs_in_c, hs_out_c;
  logic              mac_en_c, mac_clr_c, rf_we_c;
  logic [ADDR_W-1:0] a_addr_c, b_addr_c;
  logic [DATA_W-1:0] mac_a_c, mac_b_c;
  logic [ACC_W-1:0]  mac_sum_c;

  assign hs_in_c  = bus.in_valid & in_ready_q;
  assign hs_out_c = bus.out_ready & out_valid_q;

  // A occupies rf[0 .. N*N-1], B follows; both row-major.
  assign a_addr_c = ADDR_W'(i_q) * ADDR_W'(N) + ADDR_W'(k_q);
  assign b_addr_c = ADDR_W'(N * N) + ADDR_W'(k_q) * ADDR_W'(N) + ADDR_W'(j_q);

  // Operands forced to zero outside MAC so the start-time clear leaves acc at 0.
  assign mac_a_c = (state == MAC) ? rf[a_addr_c] : '0;
  assign mac_b_c = (state == MAC) ? rf[b_addr_c] : '0;

  matmul_mac #(
    .OP_W  (DATA_W),
    .SUM_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (mac_a_c),
    .b     (mac_b_c),
    .clr   (mac_clr_c),
    .en    (mac_en_c),
    .acc   (mac_sum_c)
  );

`ifndef MATMUL_SAT_EN
  logic unused_sum_hi_c;
  assign unused_sum_hi_c = ^mac_sum_c[ACC_W-1:OUT_W];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state, counters and registered-output next values.
  always_comb begin
    state_n     = state;
    i_n         = i_q;
    j_n         = j_q;
    k_n         = k_q;
    ld_n        = ld_q;
    in_ready_n  = in_ready_q;
    out_valid_n = out_valid_q;
    out_data_n  = out_data_q;
    busy_n      = busy_q;
    done_n      = 1'b0;
    ovf_n       = ovf_q;
    mac_en_c    = 1'b0;
    mac_clr_c   = 1'b0;
    rf_we_c     = 1'b0;

    case (state)
      IDLE: begin
        // start coinciding with the done pulse is deliberately ignored
        if (bus.start && !done_q) begin
          state_n    = LOAD;
          i_n        = '0;
          j_n        = '0;
          k_n        = '0;
          ld_n       = '0;
          ovf_n      = 1'b0;
          in_ready_n = 1'b1;
          busy_n     = 1'b1;
          mac_en_c   = 1'b1;
          mac_clr_c  = 1'b1;
        end
      end

      LOAD: begin
        if (hs_in_c) begin
          rf_we_c = 1'b1;
          ld_n    = ld_q + ADDR_W'(1);
          if (ld_q == ADDR_W'(LAST_BEAT)) begin
            state_n    = MAC;
            in_ready_n = 1'b0;
          end
        end
      end

      MAC: begin
        mac_en_c  = 1'b1;
        mac_clr_c = (k_q == '0);
        if (k_q == IDX_W'(N - 1)) begin
          state_n     = OUT;
          k_n         = '0;
          out_valid_n = 1'b1;
`ifdef MATMUL_SAT_EN
          if (|mac_sum_c[ACC_W-1:OUT_W]) begin
            out_data_n = '1;
            ovf_n      = 1'b1;
          end else begin
            out_data_n = mac_sum_c[OUT_W-1:0];
          end
`else
          out_data_n = mac_sum_c[OUT_W-1:0];
`endif
        end else begin
          k_n = k_q + IDX_W'(1);
        end
      end

      OUT: begin
        if (hs_out_c) begin
          out_valid_n = 1'b0;
          if (i_q == IDX_W'(N - 1) && j_q == IDX_W'(N - 1)) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            state_n = MAC;
            if (j_q == IDX_W'(N - 1)) begin
              j_n = '0;
              i_n = i_q + IDX_W'(1);
            end else begin
              j_n = j_q + IDX_W'(1);
            end
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      ld_q        <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      i_q         <= i_n;
      j_q         <= j_n;
      k_q         <= k_n;
      ld_q        <= ld_n;
      in_ready_q  <= in_ready_n;
      out_valid_q <= out_valid_n;
      out_data_q  <= out_data_n;
      busy_q      <= busy_n;
      done_q      <= done_n;
      ovf_q       <= ovf_n;
    end
  end

  // Operand storage needs no reset; every entry is rewritten before use.
  always_ff @(posedge clk) begin
    if (rf_we_c) begin
      rf[ld_q] <= bus.in_data;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ovf       = ovf_q;

endmodule
